// File: rtl/fixed_point_alu_accel_bridge_if.sv
// rtl/fixed_point_alu_accel_bridge_if.sv - accel word stream and ALU handshake bundle
interface fixed_point_alu_accel_bridge_if #(
  parameter int ACCEL_WIDTH  = 16,
  parameter int OP_WIDTH     = 3,
  parameter int NUMBER_WIDTH = 32
);
  logic                    accel_can_read;
  logic                    accel_can_write;
  logic                    accel_read_enable;
  logic                    accel_write_enable;
  logic [ACCEL_WIDTH-1:0]  accel_read_data;
  logic [ACCEL_WIDTH-1:0]  accel_write_data;
  logic                    alu_start;
  logic                    alu_done;
  logic [OP_WIDTH-1:0]     alu_op;
  logic [NUMBER_WIDTH-1:0] alu_a;
  logic [NUMBER_WIDTH-1:0] alu_b;
  logic [NUMBER_WIDTH-1:0] alu_result;
  logic                    timed_out;

  modport slave (
    output accel_can_read, accel_can_write, accel_read_data,
           alu_start, alu_op, alu_a, alu_b, timed_out,
    input  accel_read_enable, accel_write_enable, accel_write_data,
           alu_done, alu_result
  );

  modport master (
    input  accel_can_read, accel_can_write, accel_read_data,
           alu_start, alu_op, alu_a, alu_b, timed_out,
    output accel_read_enable, accel_write_enable, accel_write_data,
           alu_done, alu_result
  );
endinterface

// File: rtl/fixed_point_alu_accel_bridge.sv
// rtl/fixed_point_alu_accel_bridge.sv - multi-word accel stream to fixed-point ALU bridge with watchdog
// Optional status word before the result: FIXED_POINT_ALU_ACCEL_STATUS_EN
module fixed_point_alu_accel_bridge #(
  parameter int INTEGER_PART_WIDTH    = 16,
  parameter int FRACTIONAL_PART_WIDTH = 16,
  parameter int ACCEL_WIDTH           = 16,
  parameter int OP_WIDTH              = 3,
  parameter int TIMEOUT_CYCLES        = 1024
) (
  input logic                            clk,
  input logic                            rst,
  fixed_point_alu_accel_bridge_if.slave  bus
);
  localparam int NW    = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH;
  localparam int WORDS = (NW + ACCEL_WIDTH - 1) / ACCEL_WIDTH;
  localparam int PW    = WORDS * ACCEL_WIDTH;
  localparam int CW    = (WORDS <= 4) ? 2 : $clog2(WORDS);
  localparam int DW    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] W_LAST  = CW'(WORDS - 1);
  localparam logic [DW-1:0] WD_LAST = DW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_READ_OP   = 3'd0;
  localparam logic [2:0] S_READ_A    = 3'd1;
  localparam logic [2:0] S_READ_B    = 3'd2;
  localparam logic [2:0] S_ALU_START = 3'd3;
  localparam logic [2:0] S_WORK      = 3'd4;
  localparam logic [2:0] S_RETURN    = 3'd5;
`ifdef FIXED_POINT_ALU_ACCEL_STATUS_EN
  localparam logic [2:0] S_STATUS    = 3'd6;
  localparam logic [2:0] S_AFTER_ALU = S_STATUS;
  localparam int SW = ACCEL_WIDTH - OP_WIDTH - 1;
  logic [SW-1:0] seq_q, seq_d;
`else
  localparam logic [2:0] S_AFTER_ALU = S_RETURN;
`endif

  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       wcnt_q, wcnt_d;
  logic [DW-1:0]       wd_q, wd_d;
  logic [OP_WIDTH-1:0] op_q, op_d;
  logic [NW-1:0]       a_q, a_d, b_q, b_d, res_q, res_d;
  logic                to_q, to_d;
  logic signed [PW-1:0] res_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_READ_OP;
      wcnt_q  <= '0;
      wd_q    <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      to_q    <= 1'b0;
`ifdef FIXED_POINT_ALU_ACCEL_STATUS_EN
      seq_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      wd_q    <= wd_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      to_q    <= to_d;
`ifdef FIXED_POINT_ALU_ACCEL_STATUS_EN
      seq_q   <= seq_d;
`endif
    end
  end

  // Operands shift in MS word first; after WORDS words the left pad has fallen off the top.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    wd_d    = wd_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    to_d    = to_q;
`ifdef FIXED_POINT_ALU_ACCEL_STATUS_EN
    seq_d   = seq_q;
`endif
    case (state_q)
      S_READ_OP: if (bus.accel_write_enable) begin
        op_d    = bus.accel_write_data[OP_WIDTH-1:0];
        to_d    = 1'b0;
        wcnt_d  = '0;
        state_d = S_READ_A;
      end
      S_READ_A, S_READ_B: if (bus.accel_write_enable) begin
        if (state_q == S_READ_A) a_d = NW'({a_q, bus.accel_write_data});
        else                     b_d = NW'({b_q, bus.accel_write_data});
        if (wcnt_q == W_LAST) begin
          wcnt_d  = '0;
          state_d = (state_q == S_READ_A) ? S_READ_B : S_ALU_START;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_ALU_START: begin
        wd_d    = '0;
        state_d = S_WORK;
      end
      S_WORK: begin
        wd_d = wd_q + 1'b1;
        if (bus.alu_done) begin
          res_d   = bus.alu_result;
          state_d = S_AFTER_ALU;
        end else if (TIMEOUT_CYCLES != 0 && wd_q == WD_LAST) begin
          res_d   = '1;
          to_d    = 1'b1;
          state_d = S_AFTER_ALU;
        end
      end
`ifdef FIXED_POINT_ALU_ACCEL_STATUS_EN
      S_STATUS: if (bus.accel_read_enable) state_d = S_RETURN;
`endif
      S_RETURN: if (bus.accel_read_enable) begin
        if (wcnt_q == W_LAST) begin
          wcnt_d  = '0;
          state_d = S_READ_OP;
`ifdef FIXED_POINT_ALU_ACCEL_STATUS_EN
          seq_d   = seq_q + 1'b1;
`endif
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = S_READ_OP;
    endcase
  end

  assign res_ext = PW'($signed(res_q));

  always_comb begin
    bus.accel_read_data = '0;
    if (state_q == S_RETURN)
      bus.accel_read_data = ACCEL_WIDTH'(res_ext >> (ACCEL_WIDTH * (WORDS - 1 - int'(wcnt_q))));
`ifdef FIXED_POINT_ALU_ACCEL_STATUS_EN
    if (state_q == S_STATUS)
      bus.accel_read_data = {seq_q, op_q, to_q};
`endif
  end

`ifdef FIXED_POINT_ALU_ACCEL_STATUS_EN
  assign bus.accel_can_read = (state_q == S_RETURN) || (state_q == S_STATUS);
`else
  assign bus.accel_can_read = (state_q == S_RETURN);
`endif
  assign bus.accel_can_write = (state_q == S_READ_OP) || (state_q == S_READ_A) ||
                               (state_q == S_READ_B);
  assign bus.alu_start = (state_q == S_ALU_START);
  assign bus.alu_op    = op_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.timed_out = to_q;
endmodule

// File: tb/tb_fixed_point_alu_accel_bridge.sv
// tb/tb_fixed_point_alu_accel_bridge.sv - directed bench for the fixed-point ALU accel bridge
module tb_fixed_point_alu_accel_bridge;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fixed_point_alu_accel_bridge_if #(.ACCEL_WIDTH(16), .OP_WIDTH(3), .NUMBER_WIDTH(32)) bus0();
  fixed_point_alu_accel_bridge_if #(.ACCEL_WIDTH(16), .OP_WIDTH(3), .NUMBER_WIDTH(20)) bus1();

  fixed_point_alu_accel_bridge #(.TIMEOUT_CYCLES(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fixed_point_alu_accel_bridge #(.INTEGER_PART_WIDTH(12), .FRACTIONAL_PART_WIDTH(8),
                                 .TIMEOUT_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] alu_res0 = 32'h0;
  int          alu_dly0 = 5;
  bit          alu_resp0 = 1'b1;
  logic [19:0] alu_res1 = 20'h0;
  int          starts0 = 0;
  logic [15:0] status0, status1;

  // ALU models: a done pulse alu_dly cycles after the start pulse is seen
  initial begin
    bus0.alu_done = 1'b0;
    bus0.alu_result = '0;
    forever begin
      @(negedge clk);
      if (bus0.alu_start === 1'b1 && alu_resp0) begin
        repeat (alu_dly0 - 1) @(negedge clk);
        bus0.alu_result = alu_res0;
        bus0.alu_done = 1'b1;
        @(negedge clk);
        bus0.alu_done = 1'b0;
      end
    end
  end

  initial begin
    bus1.alu_done = 1'b0;
    bus1.alu_result = '0;
    forever begin
      @(negedge clk);
      if (bus1.alu_start === 1'b1) begin
        @(negedge clk);
        bus1.alu_result = alu_res1;
        bus1.alu_done = 1'b1;
        @(negedge clk);
        bus1.alu_done = 1'b0;
      end
    end
  end

  always @(negedge clk) if (bus0.alu_start === 1'b1) starts0++;

  task automatic wr0(input logic [15:0] w);
    int n = 0;
    while (bus0.accel_can_write !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin n_cmp++; n_err++; $display("FAIL wr0_wait: can_write=%b required 1", bus0.accel_can_write); end
    bus0.accel_write_data = w;
    bus0.accel_write_enable = 1'b1;
    @(negedge clk);
    bus0.accel_write_enable = 1'b0;
  endtask

  task automatic wr1(input logic [15:0] w);
    int n = 0;
    while (bus1.accel_can_write !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin n_cmp++; n_err++; $display("FAIL wr1_wait: can_write=%b required 1", bus1.accel_can_write); end
    bus1.accel_write_data = w;
    bus1.accel_write_enable = 1'b1;
    @(negedge clk);
    bus1.accel_write_enable = 1'b0;
  endtask

  task automatic wait_rd0(output int waited);
    waited = 0;
    while (bus0.accel_can_read !== 1'b1 && waited < 100) begin @(negedge clk); waited++; end
`ifdef FIXED_POINT_ALU_ACCEL_STATUS_EN
    status0 = bus0.accel_read_data;
    bus0.accel_read_enable = 1'b1;
    @(negedge clk);
    bus0.accel_read_enable = 1'b0;
`endif
  endtask

  task automatic wait_rd1(output int waited);
    waited = 0;
    while (bus1.accel_can_read !== 1'b1 && waited < 100) begin @(negedge clk); waited++; end
`ifdef FIXED_POINT_ALU_ACCEL_STATUS_EN
    status1 = bus1.accel_read_data;
    bus1.accel_read_enable = 1'b1;
    @(negedge clk);
    bus1.accel_read_enable = 1'b0;
`endif
  endtask

  task automatic rd0(output logic [15:0] d);
    int n = 0;
    while (bus0.accel_can_read !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    d = bus0.accel_read_data;
    bus0.accel_read_enable = 1'b1;
    @(negedge clk);
    bus0.accel_read_enable = 1'b0;
  endtask

  task automatic rd1(output logic [15:0] d);
    int n = 0;
    while (bus1.accel_can_read !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    d = bus1.accel_read_data;
    bus1.accel_read_enable = 1'b1;
    @(negedge clk);
    bus1.accel_read_enable = 1'b0;
  endtask

  task automatic send_op0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    wr0({13'h0, op}); wr0(a[31:16]); wr0(a[15:0]); wr0(b[31:16]); wr0(b[15:0]);
  endtask

  task automatic test_reset;
    n_cmp++; if (bus0.accel_can_write !== 1'b1) begin n_err++; $display("FAIL rst_can_write: got %b want 1", bus0.accel_can_write); end
    n_cmp++; if (bus0.accel_can_read !== 1'b0) begin n_err++; $display("FAIL rst_can_read: got %b want 0", bus0.accel_can_read); end
    n_cmp++; if (bus0.alu_start !== 1'b0) begin n_err++; $display("FAIL rst_alu_start: got %b want 0", bus0.alu_start); end
    n_cmp++; if ({bus0.alu_op, bus0.alu_a, bus0.alu_b} !== 67'h0) begin n_err++; $display("FAIL rst_operands: got %h/%h/%h want 0", bus0.alu_op, bus0.alu_a, bus0.alu_b); end
    n_cmp++; if (bus0.timed_out !== 1'b0) begin n_err++; $display("FAIL rst_timed_out: got %b want 0", bus0.timed_out); end
    n_cmp++; if (bus0.accel_read_data !== 16'h0) begin n_err++; $display("FAIL rst_read_data: got %h want 0000", bus0.accel_read_data); end
    n_cmp++; if (bus1.accel_can_write !== 1'b1) begin n_err++; $display("FAIL rst_can_write1: got %b want 1", bus1.accel_can_write); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int s, w;
    logic [15:0] d;
    alu_res0 = 32'h0003_C000; alu_dly0 = 5; alu_resp0 = 1'b1; s = starts0;
    send_op0(3'd0, 32'h0001_8000, 32'h0002_4000);
    n_cmp++; if (bus0.alu_start !== 1'b1) begin n_err++; $display("FAIL basic_start_latency: got %b want 1", bus0.alu_start); end
    n_cmp++; if (bus0.alu_a !== 32'h0001_8000) begin n_err++; $display("FAIL basic_alu_a: got %h want 00018000", bus0.alu_a); end
    n_cmp++; if (bus0.alu_b !== 32'h0002_4000) begin n_err++; $display("FAIL basic_alu_b: got %h want 00024000", bus0.alu_b); end
    wait_rd0(w);
    n_cmp++; if (w != 5) begin n_err++; $display("FAIL basic_done_latency: got %0d want 5", w); end
    rd0(d);
    n_cmp++; if (d !== 16'h0003) begin n_err++; $display("FAIL basic_word0: got %h want 0003", d); end
    rd0(d);
    n_cmp++; if (d !== 16'hC000) begin n_err++; $display("FAIL basic_word1: got %h want c000", d); end
    n_cmp++; if (bus0.accel_can_write !== 1'b1 || bus0.accel_can_read !== 1'b0) begin n_err++; $display("FAIL basic_back_in_read_op: can_write=%b can_read=%b want 1/0", bus0.accel_can_write, bus0.accel_can_read); end
    n_cmp++; if (starts0 - s != 1) begin n_err++; $display("FAIL basic_start_pulses: got %0d want 1", starts0 - s); end
  endtask

  task automatic test_timeout;
    int w;
    logic [15:0] d;
    alu_resp0 = 1'b0;
    send_op0(3'd3, 32'h0001_0000, 32'h0002_0000);
    @(negedge clk);
    wait_rd0(w);
    n_cmp++; if (w != 16) begin n_err++; $display("FAIL timeout_latency: got %0d want 16", w); end
    rd0(d);
    n_cmp++; if (d !== 16'hFFFF) begin n_err++; $display("FAIL timeout_word0: got %h want ffff", d); end
    rd0(d);
    n_cmp++; if (d !== 16'hFFFF) begin n_err++; $display("FAIL timeout_word1: got %h want ffff", d); end
    n_cmp++; if (bus0.timed_out !== 1'b1) begin n_err++; $display("FAIL timeout_flag: got %b want 1", bus0.timed_out); end
    alu_resp0 = 1'b1;
    wr0(16'h0002);
    n_cmp++; if (bus0.timed_out !== 1'b0 || bus0.alu_op !== 3'd2) begin n_err++; $display("FAIL timeout_clear: timed_out=%b op=%0d want 0/2", bus0.timed_out, bus0.alu_op); end
  endtask

  task automatic test_ignored_enables;
    logic [31:0] a_before;
    logic [15:0] d;
    int w;
    a_before = bus0.alu_a;
    alu_res0 = 32'h89AB_CDEF;
    bus0.accel_read_enable = 1'b1;
    @(negedge clk);
    bus0.accel_read_enable = 1'b0;
    n_cmp++; if (bus0.accel_can_write !== 1'b1 || bus0.accel_can_read !== 1'b0 || bus0.alu_a !== a_before) begin n_err++; $display("FAIL ign_read_in_read_a: can_write=%b can_read=%b a=%h want 1/0/%h", bus0.accel_can_write, bus0.accel_can_read, bus0.alu_a, a_before); end
    wr0(16'h1234); wr0(16'h5678); wr0(16'h0000); wr0(16'h0001);
    n_cmp++; if (bus0.alu_start !== 1'b1 || bus0.alu_a !== 32'h1234_5678 || bus0.alu_b !== 32'h1) begin n_err++; $display("FAIL ign_word_count: start=%b a=%h b=%h want 1/12345678/00000001", bus0.alu_start, bus0.alu_a, bus0.alu_b); end
    wait_rd0(w);
    bus0.accel_write_data = 16'hFFFF;
    bus0.accel_write_enable = 1'b1;
    @(negedge clk);
    bus0.accel_write_enable = 1'b0;
    n_cmp++; if (bus0.accel_can_read !== 1'b1 || bus0.accel_read_data !== 16'h89AB || bus0.alu_op !== 3'd2) begin n_err++; $display("FAIL ign_write_in_return: can_read=%b data=%h op=%0d want 1/89ab/2", bus0.accel_can_read, bus0.accel_read_data, bus0.alu_op); end
    rd0(d);
    n_cmp++; if (d !== 16'h89AB) begin n_err++; $display("FAIL ign_word0: got %h want 89ab", d); end
    rd0(d);
    n_cmp++; if (d !== 16'hCDEF) begin n_err++; $display("FAIL ign_word1: got %h want cdef", d); end
  endtask

  task automatic test_reset_mid;
    int w;
    logic [15:0] d;
    alu_resp0 = 1'b0;
    send_op0(3'd1, 32'h1111_2222, 32'h3333_4444);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus0.accel_can_write !== 1'b1 || bus0.accel_can_read !== 1'b0 || bus0.alu_start !== 1'b0) begin n_err++; $display("FAIL rstwork_handshake: can_write=%b can_read=%b start=%b want 1/0/0", bus0.accel_can_write, bus0.accel_can_read, bus0.alu_start); end
    n_cmp++; if ({bus0.alu_op, bus0.alu_a, bus0.alu_b, bus0.timed_out} !== 68'h0) begin n_err++; $display("FAIL rstwork_regs: op=%h a=%h b=%h to=%b want 0", bus0.alu_op, bus0.alu_a, bus0.alu_b, bus0.timed_out); end
    @(negedge clk);
    rst = 1'b0;
    alu_resp0 = 1'b1; alu_res0 = 32'h0000_0005;
    send_op0(3'd4, 32'h0000_0001, 32'h0000_0002);
    wait_rd0(w);
    rd0(d);
    n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL rstret_word0: got %h want 0000", d); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus0.accel_can_read !== 1'b0 || bus0.accel_read_data !== 16'h0 || bus0.accel_can_write !== 1'b1) begin n_err++; $display("FAIL rstret_outputs: can_read=%b data=%h can_write=%b want 0/0000/1", bus0.accel_can_read, bus0.accel_read_data, bus0.accel_can_write); end
    @(negedge clk);
    rst = 1'b0;
    alu_res0 = 32'hFEDC_BA98;
    send_op0(3'd7, 32'h0000_0003, 32'h0000_0004);
    wait_rd0(w);
    rd0(d);
    n_cmp++; if (d !== 16'hFEDC) begin n_err++; $display("FAIL rstafter_word0: got %h want fedc", d); end
    rd0(d);
    n_cmp++; if (d !== 16'hBA98 || bus0.alu_op !== 3'd7) begin n_err++; $display("FAIL rstafter_word1: got %h op=%0d want ba98/7", d, bus0.alu_op); end
  endtask

  task automatic test_narrow;
    int w;
    logic [15:0] d;
    alu_res1 = 20'h8_0000;
    wr1(16'h0005); wr1(16'hABC1); wr1(16'h2345); wr1(16'h0007); wr1(16'h0080);
    n_cmp++; if (bus1.alu_a !== 20'h1_2345) begin n_err++; $display("FAIL narrow_alu_a: got %h want 12345", bus1.alu_a); end
    n_cmp++; if (bus1.alu_b !== 20'h7_0080 || bus1.alu_op !== 3'd5) begin n_err++; $display("FAIL narrow_alu_b_op: got %h/%0d want 70080/5", bus1.alu_b, bus1.alu_op); end
    wait_rd1(w);
    rd1(d);
    n_cmp++; if (d !== 16'hFFF8) begin n_err++; $display("FAIL narrow_word0_sext: got %h want fff8", d); end
    rd1(d);
    n_cmp++; if (d !== 16'h0000) begin n_err++; $display("FAIL narrow_word1: got %h want 0000", d); end
    n_cmp++; if (bus1.accel_can_write !== 1'b1) begin n_err++; $display("FAIL narrow_read_op: can_write=%b want 1", bus1.accel_can_write); end
  endtask

`ifdef FIXED_POINT_ALU_ACCEL_STATUS_EN
  task automatic test_status;
    int w;
    logic [15:0] d;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    alu_resp0 = 1'b1; alu_res0 = 32'h0000_0100;
    send_op0(3'd2, 32'h1, 32'h2);
    wait_rd0(w);
    n_cmp++; if (status0 !== 16'h0004) begin n_err++; $display("FAIL status_op1: got %h want 0004", status0); end
    rd0(d); rd0(d);
    alu_resp0 = 1'b0;
    send_op0(3'd6, 32'h3, 32'h4);
    wait_rd0(w);
    n_cmp++; if (status0 !== 16'h001D) begin n_err++; $display("FAIL status_op2: got %h want 001d", status0); end
    rd0(d);
    n_cmp++; if (d !== 16'hFFFF) begin n_err++; $display("FAIL status_op2_word0: got %h want ffff", d); end
    rd0(d);
    alu_resp0 = 1'b1;
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus0.accel_read_enable = 1'b0; bus0.accel_write_enable = 1'b0; bus0.accel_write_data = '0;
    bus1.accel_read_enable = 1'b0; bus1.accel_write_enable = 1'b0; bus1.accel_write_data = '0;
    repeat (2) @(negedge clk);
    test_reset;
    test_basic;
    test_timeout;
    test_ignored_enables;
    test_reset_mid;
    test_narrow;
`ifdef FIXED_POINT_ALU_ACCEL_STATUS_EN
    test_status;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
